// File: rtl/bchecc_gfdiv_pkg.sv
// bchecc_gfdiv_pkg: GF(2^13) constants, FSM states and the polynomial reduction shared by the squarer and multiplier
package bchecc_gfdiv_pkg;
  localparam int GF_M = 13;
  localparam int GF_ITER = 12;
  localparam logic [GF_M-1:0] GF_POLY = 13'h001B;
  typedef enum logic [1:0] {IDLE = 2'd0, INV = 2'd1, MUL = 2'd2} state_t;
  function automatic logic [GF_M-1:0] gf_reduce(input logic [2*GF_M-2:0] p);
    logic [2*GF_M-2:0] v;
    v = p;
    for (int i = 2*GF_M-2; i >= GF_M; i--)
      if (v[i]) v[i-GF_M +: GF_M+1] = v[i-GF_M +: GF_M+1] ^ {1'b1, GF_POLY};
    return v[GF_M-1:0];
  endfunction
endpackage

// File: rtl/bchecc_gfmult.sv
// bchecc_gfmult: combinational GF(2^13) multiplier, carry-free product reduced by x^13+x^4+x^3+x+1
module bchecc_gfmult
  import bchecc_gfdiv_pkg::*;
(
  input  logic [GF_M-1:0] i_a,
  input  logic [GF_M-1:0] i_b,
  output logic [GF_M-1:0] o_p
);
  logic [2*GF_M-2:0] w_p;
  // XOR-accumulate shifted copies of a, then reduce
  always_comb begin
    w_p = '0;
    for (int i = 0; i < GF_M; i++) if (i_b[i]) w_p = w_p ^ ((2*GF_M-1)'(i_a) << i);
    o_p = gf_reduce(w_p);
  end
endmodule

// File: rtl/bchecc_gfsqr.sv
// bchecc_gfsqr: combinational GF(2^13) squarer; squaring is linear, so bits spread to even powers then reduce
module bchecc_gfsqr
  import bchecc_gfdiv_pkg::*;
(
  input  logic [GF_M-1:0] i_a,
  output logic [GF_M-1:0] o_sq
);
  logic [2*GF_M-2:0] w_sp;
  // interleave zeros between input bits and fold the high half back into the field
  always_comb begin
    w_sp = '0;
    for (int i = 0; i < GF_M; i++) w_sp[2*i] = i_a[i];
    o_sq = gf_reduce(w_sp);
  end
endmodule

// File: rtl/bchecc_gfdiv.sv
// bchecc_gfdiv: sequential GF(2^13) divider via den^(2^13-2) square-and-multiply; option BCHECC_GFDIV_EARLY_DZ_EN
module bchecc_gfdiv
  import bchecc_gfdiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [GF_M-1:0] num_i,
  input  logic [GF_M-1:0] den_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [GF_M-1:0] quo_o,
  output logic            dz_o
);
  state_t          r_state, w_next;
  logic [GF_M-1:0] r_s, r_r, r_num, r_quo;
  logic [3:0]      r_cnt;
  logic            r_dz, r_dz_o, r_done;
  logic [GF_M-1:0] w_sq, w_a, w_b, w_prod;
  logic            w_acc;
  bchecc_gfsqr u_sqr (.i_a(r_s), .o_sq(w_sq));
  bchecc_gfmult u_mul (.i_a(w_a), .i_b(w_b), .o_p(w_prod));
  assign w_acc = (r_state == IDLE) && start_i;
  assign w_a = (r_state == MUL) ? r_num : r_r;
  assign w_b = (r_state == MUL) ? r_r : w_sq;
  assign done_o = r_done;
  assign quo_o = r_quo;
  assign dz_o = r_dz_o;
`ifdef BCHECC_GFDIV_EARLY_DZ_EN
  // a zero divisor jumps straight to MUL, which forces the quotient to 0 one edge later
  always_comb begin
    w_next = w_acc ? ((den_i == '0) ? MUL : INV)
           : (r_state == INV && r_cnt == 4'(GF_ITER-1)) ? MUL
           : (r_state == MUL) ? IDLE : r_state;
  end
  assign busy_o = (r_state != IDLE) | (r_done & ~r_dz_o);
`else
  // fixed sequence IDLE -> 12x INV -> MUL -> IDLE regardless of operands
  always_comb begin
    w_next = w_acc ? INV
           : (r_state == INV && r_cnt == 4'(GF_ITER-1)) ? MUL
           : (r_state == MUL) ? IDLE : r_state;
  end
  assign busy_o = (r_state != IDLE) | r_done;
`endif
  // datapath: latch operands, iterate s<=s^2 / r<=r*s^2, then num*r into the held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s <= '0;
      r_r <= '0;
      r_num <= '0;
      r_cnt <= '0;
      r_dz <= 1'b0;
      r_dz_o <= 1'b0;
      r_quo <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= 1'b0;
      if (w_acc) begin
        r_num <= num_i;
        r_s <= den_i;
        r_r <= 13'h0001;
        r_cnt <= '0;
        r_dz <= (den_i == '0);
      end
      if (r_state == INV) begin
        r_s <= w_sq;
        r_r <= w_prod;
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == MUL) begin
        r_quo <= r_dz ? '0 : w_prod;
        r_dz_o <= r_dz;
        r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bchecc_gfdiv.sv
// tb_bchecc_gfdiv: directed and random scoreboard bench for the GF(2^13) divider
module tb_bchecc_gfdiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [12:0] num_i = '0;
  logic [12:0] den_i = '0;
  logic        busy_o, done_o, dz_o;
  logic [12:0] quo_o;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  typedef struct packed {
    logic [12:0] num;
    logic [12:0] den;
    logic [12:0] quo;
    logic        dz;
    logic        exact;
    logic [31:0] acc;
  } ent_t;
  ent_t sb[$];

  bchecc_gfdiv dut (.clk(clk), .rst_n(rst_n), .start_i(start_i), .num_i(num_i), .den_i(den_i),
                    .busy_o(busy_o), .done_o(done_o), .quo_o(quo_o), .dz_o(dz_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] acc = '0;
    for (int i = 12; i >= 0; i--) begin
      acc = {acc[11:0], 1'b0} ^ (acc[12] ? 13'h001B : 13'h0000);
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      ent_t e;
      done_cnt++;
      chk("spurious_done", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("latency", 32'(cyc) - e.acc, 32'd13);
        chk("busy_in_done", 32'(busy_o), 32'd1);
        chk("dz", 32'(dz_o), 32'(e.dz));
        if (e.exact) chk("quo", 32'(quo_o), 32'(e.quo));
        else chk("quo_times_den", 32'(gmul(quo_o, e.den)), 32'(e.num));
      end
    end
  end

  task automatic issue(input logic [12:0] n, input logic [12:0] d, input logic [12:0] q,
                       input logic z, input logic ex);
    ent_t e;
    start_i = 1'b1;
    num_i = n;
    den_i = d;
    e.num = n; e.den = d; e.quo = q; e.dz = z; e.exact = ex; e.acc = 32'(cyc + 1);
    sb.push_back(e);
  endtask

  task automatic wait_done;
    int k = 0;
    while (done_o !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("timeout", 32'(k < 20), 32'd1);
  endtask

  task automatic do_op(input logic [12:0] n, input logic [12:0] d, input logic [12:0] q,
                       input logic z, input logic ex);
    @(negedge clk);
    issue(n, d, q, z, ex);
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_quo", 32'(quo_o), 32'd0);
    chk("rst_dz", 32'(dz_o), 32'd0);
    rst_n = 1'b1;
    do_op(13'h0001, 13'h0001, 13'h0001, 1'b0, 1'b1);
    do_op(13'h0001, 13'h0002, 13'h100D, 1'b0, 1'b1);
    do_op(13'h0004, 13'h0002, 13'h0002, 1'b0, 1'b1);
    do_op(13'h1ABC, 13'h1ABC, 13'h0001, 1'b0, 1'b1);
    do_op(13'h0F0F, 13'h0000, 13'h0000, 1'b1, 1'b1);
    do_op(13'h0000, 13'h0055, 13'h0000, 1'b0, 1'b1);
    do_op(13'h1FFF, 13'h1FFF, 13'h0001, 1'b0, 1'b1);
    // starts while busy are dropped
    snap = done_cnt;
    @(negedge clk);
    issue(13'h0123, 13'h0456, 13'h0000, 1'b0, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    start_i = 1'b1; num_i = 13'h0005; den_i = 13'h0007;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    repeat (16) @(negedge clk);
    chk("single_done", 32'(done_cnt - snap), 32'd1);
    // start in the done cycle is accepted
    @(negedge clk);
    issue(13'h0001, 13'h0002, 13'h100D, 1'b0, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    issue(13'h0004, 13'h0002, 13'h0002, 1'b0, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    @(negedge clk);
    chk("b2b_idle", 32'(busy_o), 32'd0);
    // reset mid-inversion aborts
    @(negedge clk);
    issue(13'h0ABC, 13'h0123, 13'h0000, 1'b0, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    snap = done_cnt;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_quo", 32'(quo_o), 32'd0);
    chk("abort_dz", 32'(dz_o), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - snap), 32'd0);
    do_op(13'h0001, 13'h0002, 13'h100D, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++)
      do_op(13'($urandom_range(0, 8191)), 13'($urandom_range(1, 8191)), 13'h0000, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
